// File: rtl/mult_arbiter_pkg.sv
// Shared types and widths for the round-robin multiplier arbiter.
package mult_arb_pkg;

    // Operand and product widths of the shared 4x4 shift-add multiplier.
    localparam int unsigned OPW  = 4;
    localparam int unsigned RESW = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        BUSY,
        DONE
    } arb_state_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// Handshake between the arbiter and the shared sequential multiplier.
interface mult_arbiter_if;
    import mult_arb_pkg::*;

    logic            mult_start;
    logic [OPW-1:0]  mult_Min;
    logic [OPW-1:0]  mult_Qin;
    logic            mult_ready;
    logic [RESW-1:0] mult_AQ;

    // The arbiter drives start and operands; the multiplier answers ready and the product.
    modport master (
        output mult_start,
        output mult_Min,
        output mult_Qin,
        input  mult_ready,
        input  mult_AQ
    );

    modport slave (
        input  mult_start,
        input  mult_Min,
        input  mult_Qin,
        output mult_ready,
        output mult_AQ
    );

endinterface

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational cyclic priority picker: first set request at or after ptr.
module rr_pick #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [N-1:0] rot;
    logic [IW:0]  sum;

    // Rotate so bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        rot   = N'({req, req} >> ptr);
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        // Scan from the far end so the nearest hit is the last assignment.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                sum   = {1'b0, ptr} + (IW + 1)'(k);
                if (sum >= (IW + 1)'(N)) begin
                    sum = sum - (IW + 1)'(N);
                end
                idx = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin scheduler sharing one sequential multiplier between N requesters,
// with a watchdog that aborts a transaction if the multiplier stalls.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned N       = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [OPW*N-1:0] m_in,
    input  logic [OPW*N-1:0] q_in,
    output logic [N-1:0]     grant,
    output logic [N-1:0]     done,
    output logic [RESW-1:0]  result,
    output logic             err,
    mult_arbiter_if.master   mult
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [OPW-1:0]  min_q, min_d;
    logic [OPW-1:0]  qin_q, qin_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RESW-1:0] result_q, result_d;
    logic            err_q, err_d;

    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic            expired;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // The cycle that would bring the watchdog count up to TIMEOUT.
    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    // Next-state logic: arbitration, launch handshake, completion and watchdog.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        min_d    = min_q;
        qin_d    = qin_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = LAUNCH;
                    owner_d = pick_idx;
                    grant_d = N'(1) << pick_idx;
                    min_d   = m_in[pick_idx*OPW +: OPW];
                    qin_d   = q_in[pick_idx*OPW +: OPW];
                    cnt_d   = '0;
                end
            end
            LAUNCH: begin
                cnt_d = cnt_q + 1'b1;
                if (expired) begin
                    state_d  = DONE;
                    result_d = '0;
                    err_d    = 1'b1;
                end else if (!mult.mult_ready) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // A completion arriving together with expiry still counts as good.
                if (mult.mult_ready) begin
                    state_d  = DONE;
                    result_d = mult.mult_AQ;
                    err_d    = 1'b0;
                end else if (expired) begin
                    state_d  = DONE;
                    result_d = '0;
                    err_d    = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                err_d   = 1'b0;
                ptr_d   = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            min_q    <= '0;
            qin_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            min_q    <= min_d;
            qin_q    <= qin_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Outputs: start is held through LAUNCH and BUSY, done is the held grant in DONE.
    always_comb begin
        mult.mult_start = (state_q == LAUNCH) || (state_q == BUSY);
        mult.mult_Min   = min_q;
        mult.mult_Qin   = qin_q;
        grant           = grant_q;
        done            = (state_q == DONE) ? grant_q : '0;
        result          = result_q;
        err             = err_q;
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized scoreboard bench for mult_arbiter with a behavioural multiplier.
module tb_mult_arbiter;
    import mult_arb_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 20;

    logic             clock = 1'b0;
    logic             rst   = 1'b1;
    logic [N-1:0]     req   = '0;
    logic [OPW*N-1:0] m_in  = '0;
    logic [OPW*N-1:0] q_in  = '0;
    logic [N-1:0]     grant;
    logic [N-1:0]     done;
    logic [RESW-1:0]  result;
    logic             err;

    mult_arbiter_if mif ();

    mult_arbiter #(
        .N       (N),
        .TIMEOUT (TO)
    ) dut (
        .clock  (clock),
        .rst    (rst),
        .req    (req),
        .m_in   (m_in),
        .q_in   (q_in),
        .grant  (grant),
        .done   (done),
        .result (result),
        .err    (err),
        .mult   (mif)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Multiplier model: accepts on start while idle, product after lat_cfg+1 cycles,
    // never finishes while stall is set, and aborts when start drops.
    int          lat_cfg = 2;
    bit          stall   = 1'b0;
    bit          m_busy;
    bit          m_armed;
    int          m_lat;
    logic [7:0]  m_prod;

    always @(posedge clock) begin
        if (rst) begin
            mif.mult_ready <= 1'b1;
            mif.mult_AQ    <= '0;
            m_busy         <= 1'b0;
            m_armed        <= 1'b1;
            m_lat          <= 0;
        end else if (!mif.mult_start) begin
            m_armed <= 1'b1;
            if (m_busy) begin
                m_busy         <= 1'b0;
                mif.mult_ready <= 1'b1;
            end
        end else if (m_armed && !m_busy) begin
            m_armed        <= 1'b0;
            m_busy         <= 1'b1;
            mif.mult_ready <= 1'b0;
            mif.mult_AQ    <= 8'($urandom);
            m_lat          <= lat_cfg;
            m_prod         <= mif.mult_Min * mif.mult_Qin;
        end else if (m_busy && !stall) begin
            if (m_lat == 0) begin
                mif.mult_ready <= 1'b1;
                mif.mult_AQ    <= m_prod;
                m_busy         <= 1'b0;
            end else begin
                m_lat <= m_lat - 1;
            end
        end
    end

    // Scoreboard of expected completions in service order.
    typedef struct {
        int         owner;
        logic [7:0] res;
        bit         e;
    } exp_t;

    exp_t sb[$];
    int   op_m[N];
    int   op_q[N];
    int   mp = 0;

    // Reference arbitration: nearest pending requester at or after p, cyclically.
    function automatic int pick(input logic [N-1:0] pend, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (((pend >> idx) & N'(1)) != '0) return idx;
        end
        return 0;
    endfunction

    task automatic set_op(input int i, input int m, input int q);
        op_m[i] = m;
        op_q[i] = q;
        m_in[i*OPW +: OPW] = OPW'(m);
        q_in[i*OPW +: OPW] = OPW'(q);
    endtask

    // Raise mask together; hold_n > 0 keeps requests high for that many completions.
    task automatic run_batch(input logic [N-1:0] mask, input bit e, input int hold_n);
        logic [N-1:0] pend;
        int           total;
        int           n;
        int           budget;
        exp_t         x;
        pend  = mask;
        total = (hold_n > 0) ? hold_n : $countones(mask);
        for (int t = 0; t < total; t++) begin
            x.owner = pick(pend, mp);
            x.e     = e;
            x.res   = e ? 8'd0 : 8'(op_m[x.owner] * op_q[x.owner]);
            sb.push_back(x);
            if (hold_n == 0) pend = pend & ~(N'(1) << x.owner);
            mp = (x.owner + 1) % N;
        end
        req    = mask;
        n      = 0;
        budget = total * (TO + 12) + 20;
        while (n < total && budget > 0) begin
            @(negedge clock);
            budget--;
            if (hold_n == 0) begin
                // Operands of an already granted requester must no longer matter.
                for (int i = 0; i < N; i++) begin
                    if (grant[i]) begin
                        m_in[i*OPW +: OPW] = OPW'($urandom);
                        q_in[i*OPW +: OPW] = OPW'($urandom);
                    end
                end
            end
            if (done != '0) begin
                n++;
                if (hold_n == 0) req = req & ~done;
                else if (n == total) req = '0;
            end
        end
        if (n < total) begin
            chk("batch_complete", 32'(n), 32'(total));
            sb.delete();
            req = '0;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_result"}, 32'(result), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_start"}, 32'(mif.mult_start), 0);
        chk({tag, "_min"}, 32'(mif.mult_Min), 0);
        chk({tag, "_qin"}, 32'(mif.mult_Qin), 0);
    endtask

    // Monitor: pops the scoreboard on every done and checks protocol invariants.
    int         cyc = 0;
    int         launch_cyc = 0;
    logic       prev_start = 1'b0;
    int         low_cnt = 0;
    bit         seen_fall = 1'b0;
    logic [1:0] rdy_hist = '0;

    always @(negedge clock) begin
        exp_t x;
        cyc++;
        if (rst) begin
            prev_start = 1'b0;
            low_cnt    = 0;
            seen_fall  = 1'b0;
            rdy_hist   = '0;
        end else begin
            chk("grant_onehot", 32'($onehot0(grant)), 1);
            if (!mif.mult_start && done == '0) chk("grant_idle", 32'(grant), 0);
            if (mif.mult_start && !prev_start) begin
                if (seen_fall) chk("start_gap", 32'(low_cnt >= 2), 1);
                launch_cyc = cyc;
            end
            if (!mif.mult_start) begin
                if (prev_start) begin
                    seen_fall = 1'b1;
                    low_cnt   = 0;
                end
                low_cnt++;
            end
            if (done != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 0);
                end else begin
                    x = sb.pop_front();
                    chk("done_owner", 32'(done), 32'(N'(1) << x.owner));
                    chk("grant_held", 32'(grant), 32'(N'(1) << x.owner));
                    chk("result", 32'(result), 32'(x.res));
                    chk("err", 32'(err), 32'(x.e));
                    if (x.e) chk("timeout_latency", 32'(cyc - launch_cyc), TO);
                    else chk("done_after_ready", 32'(rdy_hist), 32'(2'b01));
                end
            end else begin
                chk("err_quiet", 32'(err), 0);
            end
            prev_start = mif.mult_start;
            rdy_hist   = {rdy_hist[0], mif.mult_ready};
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int budget;
        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clock);
        check_zero("reset");
        rst = 1'b0;

        // Single request: 3 * 5.
        set_op(0, 3, 5);
        run_batch(4'b0001, 1'b0, 0);

        // Fresh reset, then two simultaneous requests served 0 then 1.
        repeat (2) @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        mp  = 0;
        set_op(0, 2, 4);
        set_op(1, 3, 4);
        run_batch(4'b0011, 1'b0, 0);

        // Edge operands and pointer wrap from requester 3 back to 0.
        set_op(3, 15, 15);
        run_batch(4'b1000, 1'b0, 0);
        set_op(0, 1, 2);
        set_op(3, 15, 15);
        run_batch(4'b1001, 1'b0, 0);

        // Fairness with two requesters held continuously.
        set_op(0, 6, 7);
        set_op(1, 9, 9);
        run_batch(4'b0011, 1'b0, 6);

        // Stalled multiplier triggers the watchdog.
        stall = 1'b1;
        set_op(0, 7, 9);
        run_batch(4'b0001, 1'b1, 0);
        stall = 1'b0;
        repeat (3) @(negedge clock);

        // Randomized request sets, operands and multiplier latency.
        repeat (30) begin
            lat_cfg = $urandom_range(0, 6);
            for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 15), $urandom_range(0, 15));
            run_batch(N'($urandom_range(1, 15)), 1'b0, 0);
        end

        // Reset mid-BUSY abandons the transaction and clears the pointer.
        lat_cfg = 8;
        set_op(1, 5, 6);
        run_batch(4'b0010, 1'b0, 0);
        set_op(2, 11, 13);
        req    = 4'b0100;
        budget = 20;
        do begin
            @(negedge clock);
            budget--;
        end while (!(grant[2] && !mif.mult_ready) && budget > 0);
        if (budget == 0) chk("reach_busy", 32'(grant), 32'(4'b0100));
        @(negedge clock);
        rst = 1'b1;
        req = '0;
        @(negedge clock);
        check_zero("midbusy");
        rst = 1'b0;
        mp  = 0;
        repeat (10) @(negedge clock);
        lat_cfg = 1;
        set_op(1, 4, 7);
        set_op(3, 2, 9);
        run_batch(4'b1010, 1'b0, 0);

        repeat (5) @(negedge clock);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin scheduler that shares one sequential 4x4 shift-add `multiplier` instance between `N` requesters. It serialises requests and latches the granted requester's operands. It drives the multiplier's `start`/`Min`/`Qin` handshake, waits for `ready`, and returns the 8-bit product to the owning requester with a one-cycle `done` pulse. A watchdog aborts transactions if the multiplier stalls.

## Interface
- `N`, default 2: number of requesters (2..8).
- `TIMEOUT`, default 64: maximum cycles from launch to multiplier completion before abort.
- `clock`  in  1: system clock, all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  N: request per requester; operands must be valid while high.
- `m_in`  in  4*N: multiplicand per requester; slice i is bits [4i+3:4i].
- `q_in`  in  4*N: multiplier per requester; same slicing.
- `grant`  out  N: one-hot; the owner of the current transaction.
- `done`  out  N: one-cycle pulse to the owner when `result` is valid.
- `result`  out  8: product, valid only in the `done` cycle.
- `err`  out  1: pulses with `done` when the transaction timed out.
- `mult_start`  out  1: to multiplier `start`.
- `mult_Min`, `mult_Qin`  out  4 each: to multiplier operands.
- `mult_ready`  in  1: from multiplier `ready`.
- `mult_AQ`  in  8: from multiplier `AQ`.

## Operation
- FSM states:
  - IDLE: no owner.
  - LAUNCH: `mult_start`=1; wait for `mult_ready`=0, meaning the multiplier has accepted the operands.
  - BUSY: `mult_start` stays 1; wait for `mult_ready`=1.
  - DONE: one cycle; `mult_start`=0, capture and return the result.
- IDLE → LAUNCH when any `req` bit is 1. The winner is the first set bit at or after `ptr`, searching cyclically. Record the winner's index, one-hot it into `grant`, and latch its operands into `mult_Min`/`mult_Qin`.
- LAUNCH → BUSY on `mult_ready`=0. BUSY → DONE on `mult_ready`=1.
- In DONE:
  - drive `done[owner]`=1;
  - `result` = `mult_AQ` sampled on the BUSY→DONE edge;
  - `grant` is still held;
  - set `ptr` = (owner+1) mod N.
- DONE → IDLE unconditionally.
- Operands are latched at grant. Requester operand changes after grant are ignored.
- If the requester drops `req` mid-transaction, the transaction still completes and `done` still pulses.
- A requester holding `req` high through `done` is treated as a new request in the next IDLE.
- Watchdog: a counter clears on entry to LAUNCH and increments in LAUNCH and BUSY. When it reaches `TIMEOUT`, go to DONE with `err`=1 and `result`=0.
- Reset values:
  - FSM = IDLE, `ptr`=0, counter=0;
  - `grant`=0, `done`=0, `result`=0, `err`=0;
  - `mult_start`=0, `mult_Min`=0, `mult_Qin`=0.
- Reset is honoured in every state. A reset during BUSY abandons the transaction, with no `done` pulse.
- Product width: 4x4 unsigned gives 8 bits, so there is no truncation. `result` equals `mult_AQ` exactly.

## Timing
- Request arbitration: `req` sampled high in IDLE at edge k gives `grant` and `mult_start` high after edge k.
- Minimum occupancy is 4 cycles (IDLE, LAUNCH, BUSY, DONE) plus the multiplier latency.
- `done` and `result` appear 1 cycle after `mult_ready` rises.
- `mult_start` is guaranteed low for at least 2 cycles between transactions (DONE, IDLE).
- At most one `grant` bit is ever set; `grant` is 0 in IDLE.
- Under full load, requesters are served strictly in cyclic order 0,1,...,N-1,0. Worst-case wait is N-1 transactions.
- Simultaneous `mult_ready` edge and timeout expiry in the same cycle: the normal completion wins, with `err`=0.

## Structure
- Package `mult_arb_pkg`:
  - state enum `arb_state_t` {IDLE, LAUNCH, BUSY, DONE};
  - constants `OPW`=4 and `RESW`=8.
- One sub-module, `rr_pick`: purely combinational cyclic priority picker. Inputs are `req` and `ptr`; outputs are the winner index and a `valid` flag.
- All registers live in `mult_arbiter`.

## Test plan
- Single request: `req0` with M=3, Q=5 → `grant`=01, then `done0` pulse with `result`=15, `err`=0.
- Simultaneous after reset: `req0` (2,4) and `req1` (3,4) → `req0` served first, `result`=8; then `req1`, `result`=12; never two `grant` bits.
- Fairness, N=2: both `req` held continuously for 6 transactions → grant order 0,1,0,1,0,1.
- N=4 wrap and edge operands: `req3` (15,15) then `req0` and `req3` both pending → `result`=225; next grant goes to 0 (wrap), then 3.
- Stalled multiplier model (`mult_ready` never rises) → `done0` with `err`=1 and `result`=0 exactly `TIMEOUT` cycles after launch; back to IDLE.
- `rst` asserted for 1 cycle mid-BUSY → after that edge all outputs are 0, no `done` pulse; a subsequent `req1` is served normally with `ptr`=0.
